// File: rtl/cmd_arb_pkg.sv
// Shared constants for the calculator key arbiter: FLAG bit indices,
// arbiter FSM states and the fixed-priority pick helper.
package cmd_arb_pkg;

    localparam int N_KEYS   = 4;
    localparam int KEY_PUSH = 3;
    localparam int KEY_POP  = 2;
    localparam int KEY_ADD  = 1;
    localparam int KEY_MUL  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    // Highest set index wins, so push beats pop beats add beats mult.
    function automatic logic [1:0] prio_pick(input logic [N_KEYS-1:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchronizer, stability counter, debounced level and a
// one-cycle pulse on each accepted 0->1 change of that level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic press
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             differ;
    logic             settle;

    assign differ = (sync2_reg != level_reg);
    // The sample that completes DEBOUNCE_CYCLES differing samples flips the level.
    assign settle = differ && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_raw;
            sync2_reg <= sync1_reg;
            press_reg <= settle && !level_reg;
            if (!differ) begin
                cnt_reg <= '0;
            end else if (settle) begin
                cnt_reg   <= '0;
                level_reg <= ~level_reg;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/cmd_arbiter.sv
// Turns debounced key presses into sticky pending requests and posts them
// one at a time on FLAG[3:0] until the CPU clears the posted bit.
module cmd_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_KEYS-1:0] flag_clr,
    output logic [N_KEYS-1:0] flag,
    output logic              busy,
    output logic [1:0]        grant_id,
    output logic              dropped
);

    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] pending_reg;
    logic [N_KEYS-1:0] pending_next;
    logic [N_KEYS-1:0] ack_vec;
    logic [N_KEYS-1:0] drop_vec;
    logic [N_KEYS-1:0] flag_reg;
    logic [N_KEYS-1:0] flag_next;
    logic              busy_reg;
    logic              busy_next;
    logic [1:0]        grant_reg;
    logic [1:0]        grant_next;
    logic              dropped_reg;
    arb_state_e        state_reg;
    arb_state_e        state_next;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk    (clk),
                .reset_n(reset_n),
                .key_raw(key_raw[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        flag_next  = flag_reg;
        busy_next  = busy_reg;
        grant_next = grant_reg;
        ack_vec    = '0;
        case (state_reg)
            IDLE: begin
                if (|pending_reg) begin
                    grant_next = prio_pick(pending_reg);
                    flag_next  = N_KEYS'(1) << grant_next;
                    busy_next  = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // Only the clear of the posted bit counts as an acknowledge.
                if (flag_clr[grant_reg]) begin
                    ack_vec    = N_KEYS'(1) << grant_reg;
                    flag_next  = '0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A press landing on the bit being acknowledged re-arms it instead of dropping.
    assign drop_vec     = press & pending_reg & ~ack_vec;
    assign pending_next = (pending_reg & ~ack_vec) | press;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            flag_reg    <= '0;
            busy_reg    <= 1'b0;
            grant_reg   <= 2'd0;
            dropped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            flag_reg    <= flag_next;
            busy_reg    <= busy_next;
            grant_reg   <= grant_next;
            dropped_reg <= |drop_vec;
        end
    end

    assign flag     = flag_reg;
    assign busy     = busy_reg;
    assign grant_id = grant_reg;
    assign dropped  = dropped_reg;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed scenarios plus random key/ack traffic for cmd_arbiter, checked
// against a cycle-level behavioural model of keys, pending set and poster.
module tb_cmd_arbiter;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] flag_clr;
    logic [3:0] flag;
    logic       busy;
    logic [1:0] grant_id;
    logic       dropped;

    int n_vec = 0;
    int n_err = 0;

    cmd_arbiter #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .key_raw (key_raw),
        .flag_clr(flag_clr),
        .flag    (flag),
        .busy    (busy),
        .grant_id(grant_id),
        .dropped (dropped)
    );

    always #5 clk = ~clk;

    // Reference model: raw keys seen two clocks late; a level is accepted after
    // D consecutive samples disagreeing with it; presses queue one per key.
    logic [3:0] m_raw_dly [2];
    logic [3:0] m_lvl     = '0;
    int         m_run [4] = '{0, 0, 0, 0};
    logic [3:0] m_ev      = '0;
    logic [3:0] m_pend    = '0;
    logic       m_busy    = 1'b0;
    logic [1:0] m_gid     = 2'd0;
    logic       m_dropped = 1'b0;
    logic [3:0] m_seen, m_ack, m_ev_new;
    logic [3:0] m_flag;

    assign m_flag = m_busy ? (4'b0001 << m_gid) : 4'b0000;

    initial begin
        m_raw_dly[0] = '0;
        m_raw_dly[1] = '0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_raw_dly[0] = '0; m_raw_dly[1] = '0;
            m_lvl = '0; m_ev = '0; m_pend = '0;
            m_busy = 1'b0; m_gid = 2'd0; m_dropped = 1'b0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            m_seen    = m_raw_dly[1];
            m_ack     = (m_busy && flag_clr[m_gid]) ? (4'b0001 << m_gid) : 4'b0000;
            m_dropped = |(m_ev & m_pend & ~m_ack);
            if (!m_busy) begin
                if (m_pend != 0) begin
                    m_busy = 1'b1;
                    for (int i = 0; i < 4; i++) if (m_pend[i]) m_gid = 2'(i);
                end
            end else if (m_ack != 0) begin
                m_busy = 1'b0;
            end
            m_pend   = (m_pend & ~m_ack) | m_ev;
            m_ev_new = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_seen[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == D) begin
                        m_lvl[i]    = m_seen[i];
                        m_run[i]    = 0;
                        m_ev_new[i] = m_seen[i];
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_ev         = m_ev_new;
            m_raw_dly[1] = m_raw_dly[0];
            m_raw_dly[0] = key_raw;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        n_vec++; if (flag !== 4'b0000) begin n_err++; $display("FAIL reset_flag: got %b expected 0000", flag); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        logic [3:0] exp_flag;
        key_raw = 4'b1000;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            exp_flag = (e >= 4 + D) ? 4'b1000 : 4'b0000;
            n_vec++; if (flag !== exp_flag) begin n_err++; $display("FAIL latency_edge%0d: got %b expected %b", e, flag, exp_flag); end
        end
        n_vec++; if (busy !== 1'b1 || grant_id !== 2'd3) begin n_err++; $display("FAIL latency_grant: got busy=%b id=%0d expected busy=1 id=3", busy, grant_id); end
        flag_clr = 4'b1000;
        @(negedge clk);
        flag_clr = 4'b0000;
        n_vec++; if (flag !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL latency_ack: got flag=%b busy=%b expected 0000/0", flag, busy); end
        key_raw = 4'b0000;
        cyc(10);
        n_vec++; if (flag !== 4'b0000) begin n_err++; $display("FAIL release_no_event: got %b expected 0000", flag); end
        $display("test_latency done");
    endtask

    task automatic test_bounce();
        logic [3:0] exp_flag;
        key_raw = 4'b0010;
        cyc(D - 1);
        key_raw = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_vec++; if (flag !== 4'b0000 || dropped !== 1'b0) begin n_err++; $display("FAIL bounce_quiet: got flag=%b dropped=%b expected 0000/0", flag, dropped); end
        end
        key_raw = 4'b0010;
        for (int e = 1; e <= D + 4; e++) begin
            @(negedge clk);
            exp_flag = (e == D + 4) ? 4'b0010 : 4'b0000;
            n_vec++; if (flag !== exp_flag) begin n_err++; $display("FAIL bounce_hold_edge%0d: got %b expected %b", e, flag, exp_flag); end
        end
        flag_clr = 4'b0010; @(negedge clk); flag_clr = 4'b0000;
        key_raw = 4'b0000;
        cyc(D + 4);
        $display("test_bounce done");
    endtask

    task automatic test_simultaneous();
        key_raw = 4'b0011;
        for (int k = 0; k < 20 && flag == 4'b0000; k++) @(negedge clk);
        n_vec++; if (flag !== 4'b0010) begin n_err++; $display("FAIL simul_first: got %b expected 0010", flag); end
        flag_clr = 4'b0010; @(negedge clk); flag_clr = 4'b0000;
        n_vec++; if (flag !== 4'b0000) begin n_err++; $display("FAIL simul_idle_gap: got %b expected 0000", flag); end
        @(negedge clk);
        n_vec++; if (flag !== 4'b0001 || grant_id !== 2'd0) begin n_err++; $display("FAIL simul_second: got %b id=%0d expected 0001 id=0", flag, grant_id); end
        flag_clr = 4'b0001; @(negedge clk); flag_clr = 4'b0000;
        key_raw = 4'b0000;
        cyc(D + 4);
        n_vec++; if (flag !== 4'b0000) begin n_err++; $display("FAIL simul_done: got %b expected 0000", flag); end
        $display("test_simultaneous done");
    endtask

    task automatic test_drop();
        int n_drop;
        key_raw = 4'b0100;
        for (int k = 0; k < 20 && flag == 4'b0000; k++) @(negedge clk);
        n_vec++; if (flag !== 4'b0100) begin n_err++; $display("FAIL drop_post: got %b expected 0100", flag); end
        key_raw = 4'b0000;
        cyc(D + 3);
        key_raw = 4'b0100;
        n_drop  = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dropped === 1'b1) n_drop++;
        end
        n_vec++; if (n_drop != 1) begin n_err++; $display("FAIL drop_pulse_count: got %0d expected 1", n_drop); end
        n_vec++; if (flag !== 4'b0100) begin n_err++; $display("FAIL drop_hold: got %b expected 0100", flag); end
        flag_clr = 4'b0100; @(negedge clk); flag_clr = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++; if (flag !== 4'b0000) begin n_err++; $display("FAIL drop_no_repost: got %b expected 0000", flag); end
        end
        key_raw = 4'b0000;
        cyc(D + 4);
        $display("test_drop done");
    endtask

    task automatic test_ignore_and_reset();
        key_raw = 4'b1000;
        for (int k = 0; k < 20 && flag == 4'b0000; k++) @(negedge clk);
        flag_clr = 4'b0001; @(negedge clk); flag_clr = 4'b0000;
        n_vec++; if (flag !== 4'b1000 || busy !== 1'b1) begin n_err++; $display("FAIL ignore_other_clr: got flag=%b busy=%b expected 1000/1", flag, busy); end
        #2 reset_n = 1'b0;
        #1;
        n_vec++; if (flag !== 4'b0000 || busy !== 1'b0 || grant_id !== 2'd0) begin n_err++; $display("FAIL async_reset: got flag=%b busy=%b id=%0d expected 0000/0/0", flag, busy, grant_id); end
        key_raw = 4'b0000;
        cyc(2);
        reset_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            n_vec++; if (flag !== 4'b0000 || busy !== 1'b0) begin n_err++; $display("FAIL post_reset_quiet: got flag=%b busy=%b expected 0000/0", flag, busy); end
        end
        $display("test_ignore_and_reset done");
    endtask

    task automatic test_ack_repress();
        key_raw = 4'b0010;
        for (int k = 0; k < 20 && flag == 4'b0000; k++) @(negedge clk);
        key_raw = 4'b0000;
        cyc(D + 3);
        key_raw = 4'b0010;
        cyc(D + 2);
        flag_clr = 4'b0010; @(negedge clk); flag_clr = 4'b0000;
        n_vec++; if (flag !== 4'b0000 || dropped !== 1'b0) begin n_err++; $display("FAIL repress_gap: got flag=%b dropped=%b expected 0000/0", flag, dropped); end
        @(negedge clk);
        n_vec++; if (flag !== 4'b0010 || dropped !== 1'b0) begin n_err++; $display("FAIL repress_repost: got flag=%b dropped=%b expected 0010/0", flag, dropped); end
        flag_clr = 4'b0010; @(negedge clk); flag_clr = 4'b0000;
        key_raw = 4'b0000;
        cyc(D + 4);
        $display("test_ack_repress done");
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            n_vec++; if (flag !== m_flag) begin n_err++; $display("FAIL rand_flag cyc%0d: got %b expected %b", k, flag, m_flag); end
            n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rand_busy cyc%0d: got %b expected %b", k, busy, m_busy); end
            n_vec++; if (dropped !== m_dropped) begin n_err++; $display("FAIL rand_dropped cyc%0d: got %b expected %b", k, dropped, m_dropped); end
            if (m_busy) begin
                n_vec++; if (grant_id !== m_gid) begin n_err++; $display("FAIL rand_grant cyc%0d: got %0d expected %0d", k, grant_id, m_gid); end
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) key_raw[i] = ~key_raw[i];
            end
            flag_clr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        end
        flag_clr = 4'b0000;
        key_raw  = 4'b0000;
        $display("test_random done");
    endtask

    initial begin
        reset_n  = 1'b0;
        key_raw  = 4'b0000;
        flag_clr = 4'b0000;
        cyc(3);
        test_reset();
        reset_n = 1'b1;
        cyc(2);
        test_latency();
        test_bounce();
        test_simultaneous();
        test_drop();
        test_ignore_and_reset();
        test_ack_repress();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
